pong_game_ctrl: RTL and testbench

Game-sequencing FSM for the two-player pong display. It holds the ball still between rallies and drives `gra_still` into the graphics datapath. It consumes the datapath's point pulses (`pts_1`/`pts_2`), keeps both scores, runs a frame-based serve/game-over delay, and declares the winner. It sits between the button/keyboard inputs and the pong graphics block, alongside the score/text overlay, which reads its score and state outputs.

---
 rtl/pong_game_ctrl.sv | 150 +++++++++++++++
 tb/tb_pong_game_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-sequencing FSM for the two-player pong display.
//    Freezes the ball between rallies (gra_still), keeps both scores from the
//    datapath point pulses, runs a frame-counted serve/game-over delay and
//    declares the winner. All outputs are registers or state decodes; there
//    is no input-to-output combinational path.
// Ports:
//    clk, reset          : clock, synchronous active-high reset
//    refresh_tick        : one-cycle pulse per frame (timer decrement strobe)
//    start               : debounced start level, edge-detected internally
//    pts_1, pts_2        : point levels from the datapath, sampled only in PLAY
//    gra_still           : freeze/recentre ball (high in every state but PLAY)
//    score1, score2      : 4-bit binary scores
//    game_over, winner   : high in OVER; 00 none / 01 player 1 / 10 player 2
//    state_o             : raw state encoding for the text overlay
// Build option: define PONG_MANUAL_SERVE_EN to require a start press to leave
//    NEWBALL after the countdown; otherwise NEWBALL leaves on its own.
module pong_game_ctrl #(
   parameter int WIN_SCORE   = 7,
   parameter int TIMER_TICKS = 120,
   parameter int TMR_W       = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       refresh_tick,
   input  logic       start,
   input  logic       pts_1,
   input  logic       pts_2,
   output logic       gra_still,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic       game_over,
   output logic [1:0] winner,
   output logic [1:0] state_o
);

   localparam logic [1:0] S_NEWGAME = 2'b00;
   localparam logic [1:0] S_PLAY    = 2'b01;
   localparam logic [1:0] S_NEWBALL = 2'b10;
   localparam logic [1:0] S_OVER    = 2'b11;

   localparam logic [3:0]       WIN4     = 4'(WIN_SCORE);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMER_TICKS);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
   localparam logic [TMR_W-1:0] TMR_ZERO = '0;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [TMR_W-1:0] r_timer;
   logic             r_start_d;
   logic [3:0]       r_score1;
   logic [3:0]       r_score2;
   logic [3:0]       w_score1_nxt;
   logic [3:0]       w_score2_nxt;
   logic [3:0]       w_score1_inc;
   logic [3:0]       w_score2_inc;
   logic [1:0]       r_winner;
   logic [1:0]       w_winner_nxt;
   logic             w_start_rise;
   logic             w_timer_done;
   logic             w_timer_load;

   assign w_start_rise = start & ~r_start_d;
   assign w_timer_done = (r_timer == TMR_ZERO);
   assign w_score1_inc = r_score1 + 4'd1;
   assign w_score2_inc = r_score2 + 4'd1;

   // Leaving PLAY is the only way into NEWBALL or OVER, so that exit is the
   // timer load point. Leaving PLAY also masks the rest of a held pts level.
   assign w_timer_load = (r_state == S_PLAY) && (w_state_nxt != S_PLAY);

   always_comb begin
      w_state_nxt  = r_state;
      w_score1_nxt = r_score1;
      w_score2_nxt = r_score2;
      w_winner_nxt = r_winner;
      case (r_state)
         S_NEWGAME: begin
            if (w_start_rise) begin
               w_state_nxt  = S_PLAY;
               w_score1_nxt = 4'd0;
               w_score2_nxt = 4'd0;
               w_winner_nxt = 2'b00;
            end
         end
         S_PLAY: begin
            if (pts_1 && pts_2) begin
               // Simultaneous points: replay the rally without scoring.
               w_state_nxt = S_NEWBALL;
            end else if (pts_1) begin
               w_score1_nxt = w_score1_inc;
               if (w_score1_inc == WIN4) begin
                  w_state_nxt  = S_OVER;
                  w_winner_nxt = 2'b01;
               end else begin
                  w_state_nxt = S_NEWBALL;
               end
            end else if (pts_2) begin
               w_score2_nxt = w_score2_inc;
               if (w_score2_inc == WIN4) begin
                  w_state_nxt  = S_OVER;
                  w_winner_nxt = 2'b10;
               end else begin
                  w_state_nxt = S_NEWBALL;
               end
            end
         end
         S_NEWBALL: begin
`ifdef PONG_MANUAL_SERVE_EN
            if (w_timer_done && w_start_rise) w_state_nxt = S_PLAY;
`else
            if (w_timer_done) w_state_nxt = S_PLAY;
`endif
         end
         default: begin
            // OVER: an early start press is simply lost, never queued.
            if (w_timer_done && w_start_rise) w_state_nxt = S_NEWGAME;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_NEWGAME;
         r_timer   <= TMR_ZERO;
         r_start_d <= 1'b0;
         r_score1  <= 4'd0;
         r_score2  <= 4'd0;
         r_winner  <= 2'b00;
      end else begin
         r_state   <= w_state_nxt;
         r_start_d <= start;
         r_score1  <= w_score1_nxt;
         r_score2  <= w_score2_nxt;
         r_winner  <= w_winner_nxt;
         if (w_timer_load) begin
            r_timer <= TMR_LOAD;
         end else if (refresh_tick && !w_timer_done) begin
            r_timer <= r_timer - TMR_ONE;
         end
      end
   end

   assign gra_still = (r_state != S_PLAY);
   assign game_over = (r_state == S_OVER);
   assign score1    = r_score1;
   assign score2    = r_score2;
   assign winner    = r_winner;
   assign state_o   = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

   localparam int WIN = 7;
   localparam int TT  = 120;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       refresh_tick = 1'b0;
   logic       start = 1'b0;
   logic       pts_1 = 1'b0;
   logic       pts_2 = 1'b0;
   logic       gra_still;
   logic [3:0] score1;
   logic [3:0] score2;
   logic       game_over;
   logic [1:0] winner;
   logic [1:0] state_o;

   int errors = 0;
   int checks = 0;

   // Reference model: game phase (0 new game, 1 play, 2 new ball, 3 over),
   // scores, winner code, and number of frames seen since the last countdown
   // began (the countdown is finished once TT frames have elapsed).
   int m_phase;
   int m_s1;
   int m_s2;
   int m_win;
   int m_frames;
   bit m_prev_start;

   always #5 clk = ~clk;

   pong_game_ctrl #(.WIN_SCORE(WIN), .TIMER_TICKS(TT), .TMR_W(7)) dut (
      .clk          (clk),
      .reset        (reset),
      .refresh_tick (refresh_tick),
      .start        (start),
      .pts_1        (pts_1),
      .pts_2        (pts_2),
      .gra_still    (gra_still),
      .score1       (score1),
      .score2       (score2),
      .game_over    (game_over),
      .winner       (winner),
      .state_o      (state_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      bit press;
      bit cd_over;
      int nxt;
      press   = start && !m_prev_start;
      cd_over = (m_frames >= TT);
      if (reset) begin
         m_phase = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
         m_frames = TT; m_prev_start = 1'b0;
      end else begin
         nxt = m_phase;
         if (m_phase == 0) begin
            if (press) begin
               nxt = 1; m_s1 = 0; m_s2 = 0; m_win = 0;
            end
         end else if (m_phase == 1) begin
            if (pts_1 && pts_2) nxt = 2;
            else if (pts_1) begin
               m_s1 = m_s1 + 1;
               if (m_s1 == WIN) begin nxt = 3; m_win = 1; end else nxt = 2;
            end else if (pts_2) begin
               m_s2 = m_s2 + 1;
               if (m_s2 == WIN) begin nxt = 3; m_win = 2; end else nxt = 2;
            end
         end else if (m_phase == 2) begin
`ifdef PONG_MANUAL_SERVE_EN
            if (cd_over && press) nxt = 1;
`else
            if (cd_over) nxt = 1;
`endif
         end else begin
            if (cd_over && press) nxt = 0;
         end
         if (m_phase == 1 && nxt != 1) m_frames = 0;
         else if (refresh_tick && m_frames < TT) m_frames = m_frames + 1;
         m_phase = nxt;
         m_prev_start = start;
      end
   endtask

   // One clock: model follows the edge, outputs are compared 1 time unit later.
   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      chk("state",     32'(state_o),   32'(m_phase));
      chk("gra_still", 32'(gra_still), 32'(m_phase != 1));
      chk("game_over", 32'(game_over), 32'(m_phase == 3));
      chk("score1",    32'(score1),    32'(m_s1));
      chk("score2",    32'(score2),    32'(m_s2));
      chk("winner",    32'(winner),    32'(m_win));
   endtask

   task automatic drive(input bit r, input bit s, input bit t, input bit a, input bit b);
      reset = r; start = s; refresh_tick = t; pts_1 = a; pts_2 = b;
      cyc();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic press_start();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Full countdown from NEWBALL back to PLAY in either build.
   task automatic serve();
      ticks(TT);
`ifdef PONG_MANUAL_SERVE_EN
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      start = 1'b0;
`else
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
      chk("serve_play", 32'(state_o), 32'd1);
   endtask

   initial begin
      // Reset state
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_gra",   32'(gra_still), 32'd1);
      chk("rst_score", 32'({score1, score2}), 32'd0);
      chk("rst_win",   32'({winner, game_over}), 32'd0);

      // 1: start edge enters PLAY one cycle later
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t1_play", 32'(state_o), 32'd1);
      chk("t1_gra",  32'(gra_still), 32'd0);
      chk("t1_score", 32'({score1, score2}), 32'd0);
      start = 1'b0;

      // 2: held pts_1 scores exactly once
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t2_nb",  32'(state_o), 32'd2);
      chk("t2_gra", 32'(gra_still), 32'd1);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t2_once", 32'(score1), 32'd1);
      ticks(TT);
      chk("t2_wait", 32'(state_o), 32'd2);
`ifdef PONG_MANUAL_SERVE_EN
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      start = 1'b0;
`else
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
      chk("t2_back", 32'(state_o), 32'd1);

      // 3: simultaneous points change nothing
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("t3_nb", 32'(state_o), 32'd2);
      chk("t3_scores", 32'({score1, score2}), 32'h10);
      serve();

      // 4: player 2 to the winning score
      for (int i = 0; i < WIN - 1; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         serve();
      end
      chk("t4_s2_6", 32'(score2), 32'd6);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t4_s2", 32'(score2), 32'd7);
      chk("t4_win", 32'(winner), 32'd2);
      chk("t4_go", 32'(game_over), 32'd1);
      chk("t4_over", 32'(state_o), 32'd3);
      ticks(50);
      press_start();
      chk("t4_early", 32'(state_o), 32'd3);
      ticks(TT - 50);
      press_start();
      chk("t4_newgame", 32'(state_o), 32'd0);
      chk("t4_held", 32'({score1, score2}), 32'h17);
      press_start();
      chk("t4_clear", 32'({score1, score2, winner}), 32'd0);
      chk("t4_play", 32'(state_o), 32'd1);

      // 5: reset mid-countdown with start held high
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      ticks(10);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t5_state", 32'(state_o), 32'd0);
      chk("t5_scores", 32'({score1, score2}), 32'd0);
      chk("t5_gra", 32'(gra_still), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      ticks(5);
      chk("t5_idle", 32'(state_o), 32'd0);
      press_start();
      chk("t5_play", 32'(state_o), 32'd1);

`ifdef PONG_MANUAL_SERVE_EN
      // 6: manual serve
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      ticks(60);
      press_start();
      chk("t6_early", 32'(state_o), 32'd2);
      ticks(60);
      chk("t6_nopress", 32'(state_o), 32'd2);
      ticks(10);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t6_serve", 32'(state_o), 32'd1);
      start = 1'b0;
`endif

      // Randomized play checked cycle by cycle against the model
      for (int i = 0; i < 6000; i++) begin
         bit r, s, t, a, b;
         r = ($urandom_range(0, 1499) == 0);
         s = ($urandom_range(0, 5) == 0) ? ~start : start;
         t = ($urandom_range(0, 3) != 0);
         a = ($urandom_range(0, 11) == 0);
         b = ($urandom_range(0, 11) == 0);
         drive(r, s, t, a, b);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
